// File: rtl/ahb_ram_slave_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the RAM responder.
package ahb_ram_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

endpackage

// File: rtl/ahb_slave_chk.sv
// Address-phase decode: range/size/alignment error, RAM word index and byte lanes.
module ahb_slave_chk
    import ahb_ram_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          AW          = $clog2(DEPTH_WORDS)
) (
    input  logic [31:0]   HADDR,
    input  logic [2:0]    HSIZE,
    output logic          err,
    output logic [AW-1:0] word_idx,
    output logic [3:0]    byte_en
);

    logic [32:0] limit;
    logic [31:0] offset;
    logic        out_of_range;
    logic        bad_size;
    logic        misaligned;
    logic        unused_chk;

    // 33-bit limit so a window touching the top of the map cannot wrap
    assign limit        = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
    assign out_of_range = (HADDR < BASE_ADDR) || ({1'b0, HADDR} >= limit);
    assign offset       = HADDR - BASE_ADDR;
    assign word_idx     = offset[AW+1:2];
    assign unused_chk   = ^{offset[31:AW+2], offset[1:0]};

    always_comb begin
        byte_en    = 4'b0000;
        bad_size   = 1'b0;
        misaligned = 1'b0;
        case (HSIZE)
            HSIZE_BYTE: byte_en = 4'b0001 << HADDR[1:0];
            HSIZE_HALF: begin
                byte_en    = 4'b0011 << HADDR[1:0];
                misaligned = HADDR[0];
            end
            HSIZE_WORD: begin
                byte_en    = 4'b1111;
                misaligned = (HADDR[1:0] != 2'b00);
            end
            default:    bad_size = 1'b1;
        endcase
    end

    assign err = out_of_range | bad_size | misaligned;

endmodule

// File: rtl/ahb_ram_slave.sv
// AHB-Lite RAM responder with programmable wait states and two-cycle ERROR replies.
module ahb_ram_slave
    import ahb_ram_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [1:0]  HTRANS,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int WS_M1 = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [2:0] WS_LOAD = 3'(WS_M1);

    state_t          state_reg, state_next;
    logic [2:0]      cnt_reg, cnt_next;
    logic [AW-1:0]   idx_reg;
    logic [3:0]      be_reg;
    logic            write_reg;

    logic            chk_err;
    logic [AW-1:0]   chk_idx;
    logic [3:0]      chk_be;
    logic            active;
    logic            can_accept;
    logic            accept;
    logic            mem_we;
    logic            unused_bus;

    logic [31:0]     mem [DEPTH_WORDS];

    ahb_slave_chk #(
        .BASE_ADDR  (BASE_ADDR),
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_chk (
        .HADDR   (HADDR),
        .HSIZE   (HSIZE),
        .err     (chk_err),
        .word_idx(chk_idx),
        .byte_en (chk_be)
    );

    assign active     = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    // WAIT/ERR1 hold HREADY low; gating here keeps a misbehaving master harmless
    assign can_accept = (state_reg == ST_IDLE) || (state_reg == ST_DATA) || (state_reg == ST_ERR2);
    assign accept     = HSEL && active && HREADY && can_accept;
    assign unused_bus = ^{HBURST, HMASTLOCK, HTRANS == HTRANS_BUSY};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 3'd0;
            idx_reg   <= '0;
            be_reg    <= 4'b0000;
            write_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                idx_reg   <= chk_idx;
                be_reg    <= chk_be;
                write_reg <= HWRITE;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_WAIT: begin
                if (cnt_reg == 3'd0) state_next = ST_DATA;
                else                 cnt_next   = cnt_reg - 3'd1;
            end
            ST_ERR1: state_next = ST_ERR2;
            default: begin
                if (accept) begin
                    if (chk_err) begin
                        state_next = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_next = ST_WAIT;
                        cnt_next   = WS_LOAD;
                    end else begin
                        state_next = ST_DATA;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = 32'h0;
        case (state_reg)
            ST_WAIT: HREADYOUT = 1'b0;
            ST_DATA: HRDATA    = mem[idx_reg];
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: HRESP     = HRESP_ERROR;
            default: ;
        endcase
    end

    // Error beats never reach DATA, so they can never write
    assign mem_we = (state_reg == ST_DATA) && write_reg;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_reg[i]) mem[idx_reg][i*8 +: 8] <= HWDATA[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Directed bench for ahb_ram_slave at 0, 3 and 5 wait states sharing one bus.
module tb_ahb_ram_slave;
    import ahb_ram_slave_pkg::*;

    logic        clk;
    logic        rst;
    logic [2:0]  hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] rdata [3];
    logic        ready [3];
    logic [1:0]  resp  [3];

    int total = 0;
    int bad   = 0;

    ahb_ram_slave #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .HSEL(hsel[0]), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(3'b000), .HTRANS(htrans), .HMASTLOCK(1'b0),
        .HWDATA(hwdata), .HREADY(ready[0]), .HRDATA(rdata[0]),
        .HREADYOUT(ready[0]), .HRESP(resp[0])
    );

    ahb_ram_slave #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .HSEL(hsel[1]), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(3'b000), .HTRANS(htrans), .HMASTLOCK(1'b0),
        .HWDATA(hwdata), .HREADY(ready[1]), .HRDATA(rdata[1]),
        .HREADYOUT(ready[1]), .HRESP(resp[1])
    );

    ahb_ram_slave #(.WAIT_STATES(5)) u_ws5 (
        .clk(clk), .rst(rst), .HSEL(hsel[2]), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(3'b000), .HTRANS(htrans), .HMASTLOCK(1'b0),
        .HWDATA(hwdata), .HREADY(ready[2]), .HRDATA(rdata[2]),
        .HREADYOUT(ready[2]), .HRESP(resp[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated transfer: address phase, then wait out the data phase (bounded).
    task automatic xfer(input int s, input logic w, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd,
                        output logic [31:0] rd, output int waits,
                        output logic [1:0] low_resp, output logic [1:0] fin_resp);
        hsel    = 3'b000;
        hsel[s] = 1'b1;
        haddr   = a;
        hwrite  = w;
        hsize   = sz;
        htrans  = HTRANS_NONSEQ;
        tick();
        hsel     = 3'b000;
        htrans   = HTRANS_IDLE;
        hwdata   = wd;
        waits    = 0;
        low_resp = HRESP_OKAY;
        while (ready[s] !== 1'b1 && waits < 20) begin
            low_resp = resp[s];
            waits++;
            tick();
        end
        rd       = rdata[s];
        fin_resp = resp[s];
        $display("xfer inst=%0d write=%0b addr=%h size=%0d wdata=%h rdata=%h waits=%0d resp=%0d",
                 s, w, a, sz, wd, rd, waits, fin_resp);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        for (int s = 0; s < 3; s++) begin
            total++;
            if (ready[s] !== 1'b1 || resp[s] !== 2'b00 || rdata[s] !== 32'h0) begin
                bad++;
                $display("FAIL reset_state inst=%0d: got ready=%b resp=%b rdata=%h want 1/00/0",
                         s, ready[s], resp[s], rdata[s]);
            end
        end
        rst = 1'b0;
        tick();
        total++;
        if (ready[0] !== 1'b1 || resp[0] !== 2'b00) begin
            bad++;
            $display("FAIL post_reset_idle: got ready=%b resp=%b want 1/00", ready[0], resp[0]);
        end
    endtask

    task automatic test_back_to_back();
        hsel   = 3'b001;
        haddr  = 32'h2000_0010;
        hwrite = 1'b1;
        hsize  = HSIZE_WORD;
        htrans = HTRANS_NONSEQ;
        tick();
        total++;
        if (ready[0] !== 1'b1 || resp[0] !== HRESP_OKAY) begin
            bad++;
            $display("FAIL b2b_write_phase: got ready=%b resp=%b want 1/00", ready[0], resp[0]);
        end
        hwdata = 32'hDEAD_BEEF;
        hwrite = 1'b0;
        tick();
        $display("b2b read addr=%h rdata=%h ready=%b resp=%0d", haddr, rdata[0], ready[0], resp[0]);
        total++;
        if (rdata[0] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL b2b_read_data: got %h want deadbeef", rdata[0]);
        end
        total++;
        if (ready[0] !== 1'b1 || resp[0] !== HRESP_OKAY) begin
            bad++;
            $display("FAIL b2b_read_phase: got ready=%b resp=%b want 1/00", ready[0], resp[0]);
        end
        hsel   = 3'b000;
        htrans = HTRANS_IDLE;
        tick();
        total++;
        if (rdata[0] !== 32'h0 || ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_idle_after: got rdata=%h ready=%b want 0/1", rdata[0], ready[0]);
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] rd;
        int          wt;
        logic [1:0]  lr, fr;
        xfer(0, 1'b1, 32'h2000_0013, HSIZE_BYTE, 32'hAA00_0000, rd, wt, lr, fr);
        total++;
        if (wt !== 0 || fr !== HRESP_OKAY) begin
            bad++;
            $display("FAIL byte_write_resp: got waits=%0d resp=%b want 0/00", wt, fr);
        end
        xfer(0, 1'b0, 32'h2000_0010, HSIZE_WORD, 32'h0, rd, wt, lr, fr);
        total++;
        if (rd !== 32'hAAAD_BEEF) begin
            bad++;
            $display("FAIL byte_merge: got %h want aaadbeef", rd);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        int          wt;
        logic [1:0]  lr, fr;
        xfer(1, 1'b1, 32'h2000_0010, HSIZE_WORD, 32'h1234_5678, rd, wt, lr, fr);
        total++;
        if (wt !== 3 || fr !== HRESP_OKAY) begin
            bad++;
            $display("FAIL ws3_write: got waits=%0d resp=%b want 3/00", wt, fr);
        end
        xfer(1, 1'b0, 32'h2000_0010, HSIZE_WORD, 32'h0, rd, wt, lr, fr);
        total++;
        if (wt !== 3) begin
            bad++;
            $display("FAIL ws3_read_waits: got %0d want 3", wt);
        end
        total++;
        if (rd !== 32'h1234_5678 || fr !== HRESP_OKAY || lr !== HRESP_OKAY) begin
            bad++;
            $display("FAIL ws3_read_data: got rdata=%h resp=%b lowresp=%b want 12345678/00/00",
                     rd, fr, lr);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        int          wt;
        logic [1:0]  lr, fr;
        xfer(0, 1'b1, 32'h2000_0FFC, HSIZE_WORD, 32'h0BAD_F00D, rd, wt, lr, fr);
        xfer(0, 1'b1, 32'h2000_1000, HSIZE_WORD, 32'hFFFF_FFFF, rd, wt, lr, fr);
        total++;
        if (wt !== 1 || lr !== HRESP_ERROR || fr !== HRESP_ERROR) begin
            bad++;
            $display("FAIL oor_error: got waits=%0d lowresp=%b resp=%b want 1/01/01", wt, lr, fr);
        end
        xfer(0, 1'b0, 32'h2000_0FFC, HSIZE_WORD, 32'h0, rd, wt, lr, fr);
        total++;
        if (rd !== 32'h0BAD_F00D || fr !== HRESP_OKAY) begin
            bad++;
            $display("FAIL oor_last_word: got rdata=%h resp=%b want 0badf00d/00", rd, fr);
        end
        xfer(0, 1'b0, 32'h1FFF_FFFC, HSIZE_WORD, 32'h0, rd, wt, lr, fr);
        total++;
        if (wt !== 1 || fr !== HRESP_ERROR) begin
            bad++;
            $display("FAIL below_base: got waits=%0d resp=%b want 1/01", wt, fr);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        int          wt;
        logic [1:0]  lr, fr;
        xfer(0, 1'b1, 32'h2000_0011, HSIZE_HALF, 32'h5555_5555, rd, wt, lr, fr);
        total++;
        if (wt !== 1 || lr !== HRESP_ERROR || fr !== HRESP_ERROR) begin
            bad++;
            $display("FAIL misaligned_half: got waits=%0d lowresp=%b resp=%b want 1/01/01", wt, lr, fr);
        end
        hsel   = 3'b001;
        haddr  = 32'h2000_0010;
        htrans = HTRANS_BUSY;
        tick();
        total++;
        if (ready[0] !== 1'b1 || resp[0] !== HRESP_OKAY) begin
            bad++;
            $display("FAIL busy_beat: got ready=%b resp=%b want 1/00", ready[0], resp[0]);
        end
        htrans = HTRANS_IDLE;
        tick();
        total++;
        if (ready[0] !== 1'b1 || resp[0] !== HRESP_OKAY) begin
            bad++;
            $display("FAIL idle_beat: got ready=%b resp=%b want 1/00", ready[0], resp[0]);
        end
        xfer(0, 1'b0, 32'h2000_0010, 3'b011, 32'h0, rd, wt, lr, fr);
        total++;
        if (wt !== 1 || fr !== HRESP_ERROR || rd !== 32'h0) begin
            bad++;
            $display("FAIL bad_size: got waits=%0d resp=%b rdata=%h want 1/01/0", wt, fr, rd);
        end
        xfer(0, 1'b0, 32'h2000_0010, HSIZE_WORD, 32'h0, rd, wt, lr, fr);
        total++;
        if (rd !== 32'hAAAD_BEEF) begin
            bad++;
            $display("FAIL error_no_write: got %h want aaadbeef", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int          wt;
        logic [1:0]  lr, fr;
        xfer(2, 1'b1, 32'h2000_0020, HSIZE_WORD, 32'h5555_5555, rd, wt, lr, fr);
        total++;
        if (wt !== 5) begin
            bad++;
            $display("FAIL ws5_write_waits: got %0d want 5", wt);
        end
        hsel   = 3'b100;
        haddr  = 32'h2000_0020;
        hwrite = 1'b1;
        hsize  = HSIZE_WORD;
        htrans = HTRANS_NONSEQ;
        tick();
        hsel   = 3'b000;
        htrans = HTRANS_IDLE;
        hwdata = 32'hFFFF_0000;
        tick();
        total++;
        if (ready[2] !== 1'b0) begin
            bad++;
            $display("FAIL ws5_in_wait: got ready=%b want 0", ready[2]);
        end
        rst = 1'b1;
        #1;
        $display("reset pulse inst=2 ready=%b resp=%b rdata=%h", ready[2], resp[2], rdata[2]);
        total++;
        if (ready[2] !== 1'b1 || resp[2] !== 2'b00 || rdata[2] !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: got ready=%b resp=%b rdata=%h want 1/00/0",
                     ready[2], resp[2], rdata[2]);
        end
        tick();
        rst = 1'b0;
        tick();
        xfer(2, 1'b0, 32'h2000_0020, HSIZE_WORD, 32'h0, rd, wt, lr, fr);
        total++;
        if (rd !== 32'h5555_5555 || wt !== 5) begin
            bad++;
            $display("FAIL reset_drops_write: got rdata=%h waits=%0d want 55555555/5", rd, wt);
        end
    endtask

    initial begin
        rst    = 1'b1;
        hsel   = 3'b000;
        haddr  = 32'h0;
        hwrite = 1'b0;
        hsize  = HSIZE_WORD;
        htrans = HTRANS_IDLE;
        hwdata = 32'h0;
        tick();
        test_reset();
        test_back_to_back();
        test_byte_write();
        test_wait_states();
        test_out_of_range();
        test_errors();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_ram_slave.md
Name: ahb_ram_slave

Overview:
- AHB-Lite responder with an on-chip word-addressed RAM and a configurable wait-state count.
- Sits on the far end of the CPU data-bus master in the memory controller: it receives the CPU_H* address/control/write-data signals and returns read data, ready and response.
- Detects out-of-range, unsupported-size and misaligned accesses, and answers them with the two-cycle AHB ERROR response.

Parameters:
- BASE_ADDR, 32'h2000_0000, byte address of word 0.
- DEPTH_WORDS, 1024, RAM depth in 32-bit words (power of two).
- WAIT_STATES, 0, HREADYOUT-low cycles inserted before each OKAY data phase (0..7).

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous reset, active-high
- HSEL  in  1  slave select
- HADDR  in  32  byte address (address phase)
- HWRITE  in  1  1 = write
- HSIZE  in  3  000 byte, 001 half, 010 word
- HBURST  in  3  ignored; each beat is checked independently
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HMASTLOCK  in  1  ignored
- HWDATA  in  32  write data (data phase)
- HREADY  in  1  bus-level ready; an address phase is sampled only when it is high
- HRDATA  out  32  read data (full word, lanes unshifted)
- HREADYOUT  out  1  slave ready
- HRESP  out  2  00 OKAY, 01 ERROR

Behaviour:
- Reset (async, rst=1): state IDLE, HREADYOUT=1, HRESP=00, HRDATA=0, wait counter 0, pending data-phase registers cleared. RAM contents are not cleared. Reset mid-transfer abandons the transfer, and a pending write is dropped.
- Accept condition: HSEL & HTRANS[1] & HREADY at a rising edge. IDLE/BUSY, or HSEL=0, gives a zero-wait OKAY with no access.
- On accept, register addr, write, size and the error flag.
- Error flag is set when any of these holds:
  - HADDR < BASE_ADDR or HADDR >= BASE_ADDR + 4*DEPTH_WORDS
  - HSIZE > 010
  - HSIZE=001 with HADDR[0]=1
  - HSIZE=010 with HADDR[1:0]!=00
- States:
  - IDLE: HREADYOUT=1, HRESP=OKAY.
  - WAIT: HREADYOUT=0, HRESP=OKAY; counter decrements; at 0 go to DATA.
  - DATA: HREADYOUT=1, HRESP=OKAY; read/write completes this cycle.
  - ERR1: HREADYOUT=0, HRESP=ERROR; always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR; no RAM access.
- Transitions on accept: if error, go to ERR1; else if WAIT_STATES>0, go to WAIT with counter=WAIT_STATES-1; else go to DATA.
- From DATA or ERR2: a new accept in the same cycle follows the same rule (back-to-back pipelining); otherwise go to IDLE.
- No accept can occur in WAIT or ERR1, because HREADY is low.
- Read: in DATA, HRDATA = mem[word index of registered addr], combinational from the array. HRDATA=0 in every other state. Latency from address phase to data = 1 + WAIT_STATES cycles.
- Write: at the rising edge ending DATA, HWDATA is written under byte enables:
  - byte: 0001 << addr[1:0]
  - half: 0011 << addr[1:0]
  - word: 1111
- Write followed by read of the same word: the read's data phase is at least one cycle after the write edge, so it returns the new data; no bypass is needed.
- An ERROR-response write never modifies the RAM. A master dropping to IDLE during ERR1 is legal and has no effect.

Decomposition:
- define.v holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HRESP_OKAY/ERROR
  - HSIZE_BYTE/HALF/WORD
  - state encodings
- One combinational sub-module, ahb_slave_chk: inputs HADDR, HSIZE; outputs the error flag, the word index and the 4-bit byte enable.
- The FSM, counter and RAM array stay in ahb_ram_slave.

Test Plan:
- WAIT_STATES=0: word write 0xDEADBEEF to 0x2000_0010, then a back-to-back NONSEQ read of 0x2000_0010 -> write completes one cycle after its address phase with OKAY; the read returns 0xDEADBEEF one cycle after its address phase, HREADYOUT never low.
- Byte write 0xAA to 0x2000_0013, then word read of 0x2000_0010 -> HRDATA=0xAAADBEEF.
- WAIT_STATES=3: word read of 0x2000_0010 -> HREADYOUT low exactly 3 cycles, then high with data and OKAY.
- Word write to 0x2000_1000 (out of range) -> one cycle HREADYOUT=0/HRESP=01, then HREADYOUT=1/HRESP=01; a subsequent read of 0x2000_0FFC returns its prior contents unchanged.
- Half write to 0x2000_0011 (misaligned), then HSIZE=011 read -> each gets a two-cycle ERROR; BUSY and IDLE beats in between get zero-wait OKAY.
- rst pulsed during WAIT of a write with WAIT_STATES=5 -> HREADYOUT=1, HRESP=00, HRDATA=0 immediately; the targeted word is unchanged afterwards.
